// File: rtl/seq_pattern_gen.sv
`timescale 1ns/1ps
// seq_pattern_gen
// Serial pattern generator. On an accepted start it latches the
// configuration and sends one frame bit per clock, MSB first. The frame
// is repeated a programmable number of times, with optional idle gap
// cycles between repetitions. A one-cycle done pulse follows the final
// frame.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        asynchronous, active-low reset
//   start      begin a transmission (only accepted while idle)
//   sel[1:0]   00=11011, 01=11101, 10=user pattern, 11=1101111101
//   user_pat   user pattern bits, MSB sent first
//   user_len   user pattern length, 1..7 literal, 0 means 8
//   reps       frame repetitions, 1..15 literal, 0 means 16
//   gap        idle cycles between repetitions, 0..7
//   a          serial bit stream (IDLE_LEVEL when no bit is sent)
//   a_valid    a carries a pattern bit
//   busy       accepted start through the done cycle
//   frame_end  last bit of a frame is on a
//   done       one-cycle pulse after the final frame
module seq_pattern_gen #(
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] sel,
   input  logic [7:0] user_pat,
   input  logic [2:0] user_len,
   input  logic [3:0] reps,
   input  logic [2:0] gap,
   output logic       a,
   output logic       a_valid,
   output logic       busy,
   output logic       frame_end,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

   state_t     state_q, state_d;
   logic [9:0] frame_q, frame_d;       // frame bits, left aligned (bit 9 sent first)
   logic [3:0] flen_q, flen_d;         // frame length 1..10
   logic [3:0] bit_cnt_q, bit_cnt_d;   // index of the bit currently on a
   logic [4:0] rep_cnt_q, rep_cnt_d;   // frames remaining, including the current one
   logic [2:0] gap_len_q, gap_len_d;
   logic [2:0] gap_cnt_q, gap_cnt_d;
   logic       armed_q, armed_d;       // blocks start on the first edge after reset release
   logic       a_q, a_d;
   logic       a_valid_q, a_valid_d;
   logic       busy_q, busy_d;
   logic       frame_end_q, frame_end_d;
   logic       done_q, done_d;

   // Decode of the live configuration inputs, used only when start is accepted
   logic [9:0] new_frame;
   logic [3:0] new_len;
   logic [4:0] new_reps;

   always_comb begin
      new_frame = 10'b11011_00000;
      new_len   = 4'd5;
      case (sel)
         2'b00: begin
            new_frame = 10'b11011_00000;
            new_len   = 4'd5;
         end
         2'b01: begin
            new_frame = 10'b11101_00000;
            new_len   = 4'd5;
         end
         2'b10: begin
            new_frame = {user_pat, 2'b00};
            new_len   = (user_len == 3'd0) ? 4'd8 : {1'b0, user_len};
         end
         default: begin
            new_frame = 10'b11011_11101;
            new_len   = 4'd10;
         end
      endcase
      new_reps = (reps == 4'd0) ? 5'd16 : {1'b0, reps};
   end

   always_comb begin
      state_d     = state_q;
      frame_d     = frame_q;
      flen_d      = flen_q;
      bit_cnt_d   = bit_cnt_q;
      rep_cnt_d   = rep_cnt_q;
      gap_len_d   = gap_len_q;
      gap_cnt_d   = gap_cnt_q;
      armed_d     = 1'b1;
      a_d         = IDLE_LEVEL;
      a_valid_d   = 1'b0;
      busy_d      = 1'b0;
      frame_end_d = 1'b0;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start && armed_q) begin
               frame_d     = new_frame;
               flen_d      = new_len;
               rep_cnt_d   = new_reps;
               gap_len_d   = gap;
               bit_cnt_d   = 4'd0;
               state_d     = SEND;
               a_d         = new_frame[9];
               a_valid_d   = 1'b1;
               busy_d      = 1'b1;
               frame_end_d = (new_len == 4'd1);
            end
         end

         SEND: begin
            busy_d = 1'b1;
            if (bit_cnt_q == flen_q - 4'd1) begin
               // The bit now on a closes the frame
               if (rep_cnt_q == 5'd1) begin
                  state_d   = DONE;
                  done_d    = 1'b1;
                  bit_cnt_d = 4'd0;
                  rep_cnt_d = 5'd0;
               end else begin
                  rep_cnt_d = rep_cnt_q - 5'd1;
                  bit_cnt_d = 4'd0;
                  if (gap_len_q != 3'd0) begin
                     state_d   = GAP;
                     gap_cnt_d = gap_len_q;
                  end else begin
                     // No gap: next frame's first bit follows without a bubble
                     a_d         = frame_q[9];
                     a_valid_d   = 1'b1;
                     frame_end_d = (flen_q == 4'd1);
                  end
               end
            end else begin
               bit_cnt_d   = bit_cnt_q + 4'd1;
               a_d         = frame_q[4'd8 - bit_cnt_q];
               a_valid_d   = 1'b1;
               frame_end_d = (bit_cnt_q + 4'd2 == flen_q);
            end
         end

         GAP: begin
            busy_d = 1'b1;
            if (gap_cnt_q == 3'd1) begin
               state_d     = SEND;
               gap_cnt_d   = 3'd0;
               a_d         = frame_q[9];
               a_valid_d   = 1'b1;
               frame_end_d = (flen_q == 4'd1);
            end else begin
               gap_cnt_d = gap_cnt_q - 3'd1;
            end
         end

         DONE: begin
            // start during this cycle is ignored; the idle outputs come from defaults
            state_d   = IDLE;
            bit_cnt_d = 4'd0;
            rep_cnt_d = 5'd0;
            gap_cnt_d = 3'd0;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         frame_q     <= 10'd0;
         flen_q      <= 4'd0;
         bit_cnt_q   <= 4'd0;
         rep_cnt_q   <= 5'd0;
         gap_len_q   <= 3'd0;
         gap_cnt_q   <= 3'd0;
         armed_q     <= 1'b0;
         a_q         <= IDLE_LEVEL;
         a_valid_q   <= 1'b0;
         busy_q      <= 1'b0;
         frame_end_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_q     <= frame_d;
         flen_q      <= flen_d;
         bit_cnt_q   <= bit_cnt_d;
         rep_cnt_q   <= rep_cnt_d;
         gap_len_q   <= gap_len_d;
         gap_cnt_q   <= gap_cnt_d;
         armed_q     <= armed_d;
         a_q         <= a_d;
         a_valid_q   <= a_valid_d;
         busy_q      <= busy_d;
         frame_end_q <= frame_end_d;
         done_q      <= done_d;
      end
   end

   assign a         = a_q;
   assign a_valid   = a_valid_q;
   assign busy      = busy_q;
   assign frame_end = frame_end_q;
   assign done      = done_q;

endmodule

// File: doc/seq_pattern_gen.md
SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 SHALL have parameter IDLE_LEVEL, default 1'b0, value driven on a when no pattern bit is being sent.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin transmission, sampled on clk rise.
REQ-005 SHALL have port sel  input  2  pattern select: 00=11011, 01=11101, 10=user pattern, 11=11011 followed by 11101 (10-bit frame).
REQ-006 SHALL have port user_pat  input  8  user pattern bits, MSB sent first.
REQ-007 SHALL have port user_len  input  3  user pattern length; 1..7 literal, 0 means 8.
REQ-008 SHALL have port reps  input  4  frame repetitions; 1..15 literal, 0 means 16.
REQ-009 SHALL have port gap  input  3  idle cycles inserted between repetitions, 0..7.
REQ-010 SHALL have port a  output  1  serial bit stream.
REQ-011 SHALL have port a_valid  output  1  high on every cycle a carries a pattern bit.
REQ-012 SHALL have port busy  output  1  high from accepted start through the done cycle.
REQ-013 SHALL have port frame_end  output  1  high during the cycle the last bit of each frame is driven.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the final frame.

Function
REQ-015 SHALL implement FSM states IDLE, SEND, GAP, DONE; all outputs registered.
REQ-016 IDLE: start=1 at an edge SHALL latch sel, user_pat, user_len, reps, gap and enter SEND; first bit appears on a after that same edge.
REQ-017 SEND SHALL drive one frame bit per cycle, MSB first, a_valid=1, each bit held exactly one cycle.
REQ-018 User frame SHALL be user_pat[7:8-L], L = decoded user_len.
REQ-019 Frame lengths SHALL be 5 (sel 00/01), L (sel 10), 10 (sel 11); sel 11 sends bits 1101111101.
REQ-020 On the last bit of a frame frame_end SHALL be 1; otherwise 0.
REQ-021 After a non-final frame: gap>0 -> GAP for exactly gap cycles (a=IDLE_LEVEL, a_valid=0), then SEND; gap=0 -> next frame starts the very next cycle with no bubble.
REQ-022 After the final frame SHALL enter DONE for one cycle: done=1, busy=1, a_valid=0, a=IDLE_LEVEL; then IDLE.
REQ-023 Total busy cycles SHALL equal R*F + (R-1)*gap + 1 (R = decoded reps, F = frame length).
REQ-024 start while busy SHALL be ignored; latched config SHALL NOT change until the next accepted start.
REQ-025 start high in the DONE cycle SHALL be ignored; start high in the first IDLE cycle after DONE SHALL be accepted.
REQ-026 In IDLE: a=IDLE_LEVEL, a_valid=0, busy=0, frame_end=0, done=0.
REQ-027 Bit counter SHALL be 4 bits, repetition counter 5 bits, gap counter 3 bits; no counter wraps within a legal transmission.

Reset
REQ-028 rst=0 SHALL immediately, without waiting for clk, force state IDLE, a=IDLE_LEVEL, a_valid=0, busy=0, frame_end=0, done=0, and clear all counters.
REQ-029 Reset mid-transmission SHALL abandon the frame; no done pulse; after rst=1 a new start is required.
REQ-030 start asserted during reset or on the edge releasing reset SHALL NOT be accepted unless still high at a later edge with rst=1.

Verification
REQ-031 sel=00, reps=1, gap=0, start one cycle -> a=1,1,0,1,1 over 5 cycles, a_valid 5 cycles, frame_end on 5th, done on 6th, busy 6 cycles.
REQ-032 sel=01, reps=3, gap=2 -> 11101,00,11101,00,11101 (gap bits a_valid=0), frame_end 3 times, done at cycle 20, busy 20 cycles.
REQ-033 sel=10, user_pat=8'b1011_0000, user_len=4, reps=2, gap=0 -> a=1,0,1,1,1,0,1,1 contiguous, frame_end on cycles 4 and 8, done cycle 9; user_len=0, user_pat=8'hA5 -> 10100101.
REQ-034 sel=11, reps=1 -> a=1101111101 over 10 cycles, frame_end only on 10th; sel changed to 00 and start pulsed mid-frame -> no effect.
REQ-035 rst driven low between clk edges during bit 3 -> all outputs idle values immediately; after release, no activity until next start; start held high through DONE -> second transmission begins one cycle after done.
REQ-036 reps=0, sel=00, gap=0 -> 16 frames (80 bits) then done; busy 81 cycles.
